// File: rtl/execute_mul_sched_pkg.sv
// rtl/execute_mul_sched_pkg.sv - shared widths, defaults and mul-op payload type
package execute_mul_sched_pkg;

    localparam int MUL_LAT_DEF  = 2;
    localparam int RSV_DIST_DEF = 4;
    localparam int ROB_W        = 4;
    localparam int FID_W        = 8;
    localparam int MULCMD_W     = 1;

    typedef struct packed {
        logic [31:0]         src0;
        logic [31:0]         src1;
        logic [ROB_W-1:0]    dst_rob;
        logic [FID_W-1:0]    fid;
        logic [MULCMD_W-1:0] cmd;
    } mul_op_t;

endpackage

// File: rtl/execute_mul_sched_slot.sv
// rtl/execute_mul_sched_slot.sv - writeback slot reservation and in-flight tracking
module execute_mul_sched_slot
    import execute_mul_sched_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int RSV_DIST = RSV_DIST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic wb_rsv,
    input  logic mul_valid,
    output logic slot_busy,
    output logic idle
);

    localparam int D = MUL_LAT + 1;

    // claim[j] is set when the writeback slot j cycles from now is taken;
    // the live i_wb_rsv input is the farthest-out entry.
    logic [RSV_DIST-1:1] rsv;
    logic [RSV_DIST:1]   claim;
    logic [MUL_LAT:1]    pend;

    assign claim     = {wb_rsv, rsv};
    assign slot_busy = claim[D];
    assign idle      = !mul_valid && (pend == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsv  <= '0;
            pend <= '0;
        end else begin
            rsv     <= claim[RSV_DIST:2];
            pend[1] <= mul_valid;
            for (int i = 2; i <= MUL_LAT; i++) begin
                pend[i] <= pend[i-1];
            end
        end
    end

endmodule

// File: rtl/execute_mul_sched.sv
// rtl/execute_mul_sched.sv - round-robin issue scheduler for the shared multiply unit
module execute_mul_sched
    import execute_mul_sched_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int RSV_DIST = RSV_DIST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req0_valid,
    input  logic                i_req1_valid,
    output logic                o_req0_ready,
    output logic                o_req1_ready,
    input  logic [31:0]         i_req0_src0_value,
    input  logic [31:0]         i_req0_src1_value,
    input  logic [ROB_W-1:0]    i_req0_dst_rob,
    input  logic [FID_W-1:0]    i_req0_fid,
    input  logic [MULCMD_W-1:0] i_req0_mul_cmd,
    input  logic [31:0]         i_req1_src0_value,
    input  logic [31:0]         i_req1_src1_value,
    input  logic [ROB_W-1:0]    i_req1_dst_rob,
    input  logic [FID_W-1:0]    i_req1_fid,
    input  logic [MULCMD_W-1:0] i_req1_mul_cmd,
    input  logic                i_wb_rsv,
    input  logic                i_flush,
    output logic                o_mul_valid,
    output logic [31:0]         o_mul_src0_value,
    output logic [31:0]         o_mul_src1_value,
    output logic [ROB_W-1:0]    o_mul_dst_rob,
    output logic [FID_W-1:0]    o_mul_fid,
    output logic [MULCMD_W-1:0] o_mul_cmd,
    output logic                o_idle
);

    mul_op_t op0, op1, op_q;
    logic    valid_q;
    logic    rr_ptr;
    logic    slot_busy;
    logic    can_grant;
    logic    grant0, grant1;

    assign op0 = '{src0: i_req0_src0_value, src1: i_req0_src1_value,
                   dst_rob: i_req0_dst_rob, fid: i_req0_fid, cmd: i_req0_mul_cmd};
    assign op1 = '{src0: i_req1_src0_value, src1: i_req1_src1_value,
                   dst_rob: i_req1_dst_rob, fid: i_req1_fid, cmd: i_req1_mul_cmd};

    execute_mul_sched_slot #(
        .MUL_LAT  (MUL_LAT),
        .RSV_DIST (RSV_DIST)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .wb_rsv    (i_wb_rsv),
        .mul_valid (valid_q),
        .slot_busy (slot_busy),
        .idle      (o_idle)
    );

    // Grants depend only on valids, pointer and slot state, never on a ready.
    always_comb begin
        can_grant = !slot_busy && !i_flush && !reset;
        grant0    = can_grant && i_req0_valid && (!i_req1_valid || !rr_ptr);
        grant1    = can_grant && i_req1_valid && (!i_req0_valid ||  rr_ptr);
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= '0;
        end else begin
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
            valid_q <= grant0 || grant1;
            op_q    <= grant0 ? op0 : (grant1 ? op1 : '0);
        end
    end

    assign o_mul_valid      = valid_q;
    assign o_mul_src0_value = op_q.src0;
    assign o_mul_src1_value = op_q.src1;
    assign o_mul_dst_rob    = op_q.dst_rob;
    assign o_mul_fid        = op_q.fid;
    assign o_mul_cmd        = op_q.cmd;

endmodule

// File: tb/tb_execute_mul_sched.sv
// tb/tb_execute_mul_sched.sv - self-checking bench for execute_mul_sched
module tb_execute_mul_sched;
    import execute_mul_sched_pkg::*;

    localparam int MUL_LAT  = 2;
    localparam int RSV_DIST = 4;
    localparam int D        = MUL_LAT + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_req0_valid, i_req1_valid;
    logic                o_req0_ready, o_req1_ready;
    logic [31:0]         i_req0_src0_value, i_req0_src1_value;
    logic [ROB_W-1:0]    i_req0_dst_rob;
    logic [FID_W-1:0]    i_req0_fid;
    logic [MULCMD_W-1:0] i_req0_mul_cmd;
    logic [31:0]         i_req1_src0_value, i_req1_src1_value;
    logic [ROB_W-1:0]    i_req1_dst_rob;
    logic [FID_W-1:0]    i_req1_fid;
    logic [MULCMD_W-1:0] i_req1_mul_cmd;
    logic                i_wb_rsv, i_flush;
    logic                o_mul_valid;
    logic [31:0]         o_mul_src0_value, o_mul_src1_value;
    logic [ROB_W-1:0]    o_mul_dst_rob;
    logic [FID_W-1:0]    o_mul_fid;
    logic [MULCMD_W-1:0] o_mul_cmd;
    logic                o_idle;

    always #5 clk = ~clk;

    execute_mul_sched #(.MUL_LAT(MUL_LAT), .RSV_DIST(RSV_DIST)) dut (
        .clk(clk), .reset(reset),
        .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
        .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
        .i_req0_src0_value(i_req0_src0_value), .i_req0_src1_value(i_req0_src1_value),
        .i_req0_dst_rob(i_req0_dst_rob), .i_req0_fid(i_req0_fid), .i_req0_mul_cmd(i_req0_mul_cmd),
        .i_req1_src0_value(i_req1_src0_value), .i_req1_src1_value(i_req1_src1_value),
        .i_req1_dst_rob(i_req1_dst_rob), .i_req1_fid(i_req1_fid), .i_req1_mul_cmd(i_req1_mul_cmd),
        .i_wb_rsv(i_wb_rsv), .i_flush(i_flush),
        .o_mul_valid(o_mul_valid),
        .o_mul_src0_value(o_mul_src0_value), .o_mul_src1_value(o_mul_src1_value),
        .o_mul_dst_rob(o_mul_dst_rob), .o_mul_fid(o_mul_fid), .o_mul_cmd(o_mul_cmd),
        .o_idle(o_idle)
    );

    int      n_cmp  = 0;
    int      n_fail = 0;
    int      cyc    = 0;
    bit      chk    = 0;

    // Reference model: absolute slot numbers that are claimed, the RR preference,
    // the last cycle an op was accepted, and the op expected on the mul bus.
    bit      reserved [int];
    bit      m_ptr      = 0;
    int      last_grant = -1000;
    bit      exp_valid  = 0;
    mul_op_t exp_op     = '0;

    function automatic void check(string name, logic [127:0] got, logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endfunction

    function automatic mul_op_t rand_op();
        mul_op_t o;
        o.src0    = $urandom;
        o.src1    = $urandom;
        o.dst_rob = ROB_W'($urandom);
        o.fid     = FID_W'($urandom);
        o.cmd     = MULCMD_W'($urandom);
        return o;
    endfunction

    task automatic step(input bit rst, input bit v0, input bit v1, input bit rsv, input bit fl,
                        input mul_op_t p0, input mul_op_t p1, output bit r0, output bit r1);
        mul_op_t dut_op;
        int      g;
        if (chk) begin
            dut_op = '{src0: o_mul_src0_value, src1: o_mul_src1_value,
                       dst_rob: o_mul_dst_rob, fid: o_mul_fid, cmd: o_mul_cmd};
            check("mul_valid", o_mul_valid, exp_valid);
            check("mul_op", dut_op, exp_op);
            check("idle", o_idle, (last_grant + 1 + MUL_LAT >= cyc) ? 1'b0 : 1'b1);
        end
        reset = rst; i_req0_valid = v0; i_req1_valid = v1; i_wb_rsv = rsv; i_flush = fl;
        i_req0_src0_value = p0.src0; i_req0_src1_value = p0.src1;
        i_req0_dst_rob = p0.dst_rob; i_req0_fid = p0.fid; i_req0_mul_cmd = p0.cmd;
        i_req1_src0_value = p1.src0; i_req1_src1_value = p1.src1;
        i_req1_dst_rob = p1.dst_rob; i_req1_fid = p1.fid; i_req1_mul_cmd = p1.cmd;
        #1;
        g = -1;
        if (rst) begin
            reserved.delete();
            m_ptr      = 0;
            last_grant = -1000;
        end else begin
            if (rsv) reserved[cyc + RSV_DIST] = 1'b1;
            if (!reserved.exists(cyc + D) && !fl) begin
                if (v0 && v1) g = m_ptr ? 1 : 0;
                else if (v0)  g = 0;
                else if (v1)  g = 1;
            end
        end
        check("ready0", o_req0_ready, g == 0);
        check("ready1", o_req1_ready, g == 1);
        r0 = o_req0_ready;
        r1 = o_req1_ready;
        if (g >= 0) begin
            m_ptr      = (g == 0);
            last_grant = cyc;
        end
        exp_valid = (g >= 0);
        exp_op    = (g == 0) ? p0 : ((g == 1) ? p1 : '0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk = 1;
    endtask

    typedef struct {
        bit rst, v0, v1, rsv, fl;
        bit e0, e1;
    } vec_t;

    vec_t    tbl [14];
    mul_op_t p0, p1;
    bit      r0, r1;

    initial begin
        // directed sequence: round robin, flush, slot conflict, reset mid-stream
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0, 1};
        tbl[3]  = '{0, 1, 1, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 1};
        tbl[5]  = '{0, 1, 1, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 1, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 0, 1, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 1, 1, 0, 0, 1};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 0};
        tbl[11].rst = 1;
        tbl[12] = '{0, 1, 1, 0, 0, 1, 0};
        tbl[13] = '{0, 1, 1, 0, 0, 0, 1};

        @(negedge clk);
        p0 = rand_op();
        p1 = rand_op();
        step(1, 0, 0, 0, 0, p0, p1, r0, r1);

        for (int i = 0; i < 14; i++) begin
            p0 = rand_op(); p0.dst_rob = 4'h1;
            p1 = rand_op(); p1.dst_rob = 4'h2;
            step(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].rsv, tbl[i].fl, p0, p1, r0, r1);
            check("tbl_ready0", r0, tbl[i].e0);
            check("tbl_ready1", r1, tbl[i].e1);
        end

        // single request on port 1, then idle drain
        p0 = rand_op();
        p1 = '{src0: 32'd7, src1: 32'd6, dst_rob: 4'd3, fid: 8'h5A, cmd: 1'b1};
        step(0, 0, 1, 0, 0, p0, p1, r0, r1);
        check("single_ready1", r1, 1'b1);
        check("single_valid", o_mul_valid, 1'b1);
        check("single_src0", o_mul_src0_value, 32'd7);
        check("single_src1", o_mul_src1_value, 32'd6);
        check("single_rob", o_mul_dst_rob, 4'd3);
        check("single_fid", o_mul_fid, 8'h5A);
        for (int k = 1; k <= MUL_LAT + 1; k++) begin
            check("idle_busy", o_idle, 1'b0);
            step(0, 0, 0, 0, 0, p0, p1, r0, r1);
        end
        check("idle_drained", o_idle, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            p0 = rand_op();
            p1 = rand_op();
            step($urandom_range(99) < 3, $urandom_range(99) < 70, $urandom_range(99) < 70,
                 $urandom_range(99) < 20, $urandom_range(99) < 10, p0, p1, r0, r1);
        end
        step(0, 0, 0, 0, 0, p0, p1, r0, r1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_mul_sched.md
Name: execute_mul_sched

Overview:
- Issue scheduler that shares the single pipelined multiply unit (execute_mul) between two requesters, e.g. two reservation-station issue ports.
- Arbitrates round-robin and registers the granted operation onto the multiplier inputs.
- Guarantees the multiply result never lands on the shared writeback bus in a cycle already reserved by another functional unit.
- Tracks in-flight operations, so the core can detect when the multiplier has drained.

Parameters:
- MUL_LAT, 2: cycles from o_mul_valid to the multiply unit's o_valid.
- RSV_DIST, 4: distance in cycles from i_wb_rsv to the writeback slot it claims; legal range is RSV_DIST >= MUL_LAT+1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req0_valid / i_req1_valid  in  1  request valid, port 0 / port 1.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle; combinational.
- i_reqN_src0_value, i_reqN_src1_value  in  32 each  operands, per port N.
- i_reqN_dst_rob  in  4  destination ROB entry, per port.
- i_reqN_fid  in  8  fetch id, per port.
- i_reqN_mul_cmd  in  1  multiply command, per port.
- i_wb_rsv  in  1  another unit claims the shared writeback slot RSV_DIST cycles ahead.
- i_flush  in  1  pipeline flush.
- o_mul_valid  out  1  to multiply unit i_valid.
- o_mul_src0_value, o_mul_src1_value  out  32 each  to the multiply unit.
- o_mul_dst_rob  out  4  to the multiply unit.
- o_mul_fid  out  8  to the multiply unit.
- o_mul_cmd  out  1  to the multiply unit.
- o_idle  out  1  no op held in the issue register and none in flight.

Behaviour:
- Reset, synchronous and active-high:
  - o_mul_valid=0 and all o_mul_* payload=0.
  - Round-robin pointer = 0 (port 0 preferred).
  - Reservation shift register cleared; in-flight shift register cleared.
  - o_idle=1 in the first cycle after reset.
- Reset wins over every other input, including i_flush.
- Slot check: an issue accepted at cycle t produces a result at t+1+MUL_LAT; define D = MUL_LAT+1.
- Reservation register rsv[RSV_DIST:1]:
  - Shifts toward 1 every cycle.
  - rsv[RSV_DIST] is loaded with i_wb_rsv.
  - slot_busy = rsv[D], or (i_wb_rsv when RSV_DIST==D).
- Grant condition: grant is allowed only when !slot_busy and !i_flush and !reset.
- Arbitration:
  - If only one request is valid, it is granted.
  - If both are valid, the port selected by the pointer is granted.
  - After a grant to port i, the pointer becomes 1-i.
  - With no grant, the pointer holds.
- o_reqN_ready = grant to port N. This is a valid/ready handshake: a transfer occurs when valid && ready.
- At most one ready is high per cycle. ready never depends on ready.
- Issue register:
  - On a grant, the payload of the granted port is captured and o_mul_valid=1 on the next cycle (latency 1 from accept).
  - Without a grant, o_mul_valid=0 next cycle and the payload is zeroed.
  - No backpressure from the multiplier; it accepts every cycle.
- In-flight tracker:
  - pend[MUL_LAT:1] shifts each cycle; pend[1] is loaded with o_mul_valid.
  - o_idle = !o_mul_valid && (pend == 0).
- Flush:
  - i_flush forces both readies to 0 and clears o_mul_valid next cycle.
  - Ops already in the multiplier still complete; downstream discards them by fid. pend is not cleared by flush.
  - The reservation register keeps shifting and keeps accepting i_wb_rsv during flush.
- A reservation arriving in the same cycle as a grant only affects that grant when RSV_DIST==D. In that case the reservation wins and the requester stalls.
- Requesters may hold valid indefinitely under stall; the scheduler must not drop or duplicate a request.

Decomposition:
- Shared package holds:
  - MUL_LAT default.
  - Widths ROB_W=4, FID_W=8, MULCMD_W=1.
  - A typedef for the mul-op payload struct {src0, src1, dst_rob, fid, cmd}.
- One natural sub-module: execute_mul_sched_slot. It holds the reservation and in-flight shift registers and outputs slot_busy and o_idle.
- The arbiter and issue register stay in the top.

Test Plan:
- Round robin:
  - Stimulus: both ports valid continuously after reset, no rsv.
  - Response: grants alternate 0,1,0,1; o_mul_valid high every cycle from cycle 1; o_mul_dst_rob follows the granted port.
- Single request:
  - Stimulus: port1 only, src0=7, src1=6, dst_rob=3, fid=0x5A.
  - Response: o_req1_ready=1 at t; at t+1 o_mul_valid=1 with src0=7, src1=6, rob=3, fid=0x5A.
- Slot conflict:
  - Stimulus: i_wb_rsv pulse at cycle 10 (RSV_DIST=4, D=3); port0 valid throughout.
  - Response: o_req0_ready=0 at cycle 11; grants at 10 and 12.
- Flush:
  - Stimulus: i_flush at cycle t with both ports valid.
  - Response: both readies 0 at t; o_mul_valid=0 at t+1; the pointer does not advance.
- Idle tracking:
  - Stimulus: single grant at t.
  - Response: o_idle=0 at t+1..t+1+MUL_LAT; o_idle=1 at t+2+MUL_LAT.
- Reset mid-stream:
  - Stimulus: assert reset with both ports valid and a pending rsv.
  - Response: next cycle o_mul_valid=0 and o_idle=1; the rsv is forgotten; the first grant after deassert goes to port 0.
